// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: circular buffer of (PC, instruction) pairs
// with valid/ready handshakes on both sides, branch-redirect flush and uncond-branch predecode.
module fetch_decode_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_valid,
    input  logic [63:0]                  fetch_pc,
    input  logic [31:0]                  fetch_instr,
    output logic                         fetch_ready,
    input  logic                         flush,
    output logic                         dec_valid,
    output logic [63:0]                  dec_pc,
    output logic [31:0]                  dec_instr,
    output logic                         dec_uncond_br,
    input  logic                         dec_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [5:0]  UNCOND_BR_OP = 6'b000101;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Handshake flags derive only from registered count, never from fetch_* inputs.
    assign fetch_ready = (count < CNT_W'(DEPTH));
    assign dec_valid   = (count != '0);
    assign push        = fetch_valid & fetch_ready & ~flush;
    assign pop         = dec_valid & dec_ready & ~flush;

    assign head          = dec_valid ? mem[rd_ptr] : '0;
    assign dec_pc        = head.pc;
    assign dec_instr     = head.instr;
    assign dec_uncond_br = dec_valid & (head.instr[31:26] == UNCOND_BR_OP);

    // Pointer and occupancy state; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage is never cleared; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= '{pc: fetch_pc, instr: fetch_instr};
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomized self-checking bench for fetch_decode_queue against a queue-based
// model of the fetch/decode handshake, plus directed boundary scenarios.
module tb_fetch_decode_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_valid;
    logic [63:0]   fetch_pc;
    logic [31:0]   fetch_instr;
    logic          fetch_ready;
    logic          flush;
    logic          dec_valid;
    logic [63:0]   dec_pc;
    logic [31:0]   dec_instr;
    logic          dec_uncond_br;
    logic          dec_ready;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [95:0] mq[$];
    logic [63:0] popped[$];
    int          max_count;

    fetch_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_instr   (fetch_instr),
        .fetch_ready   (fetch_ready),
        .flush         (flush),
        .dec_valid     (dec_valid),
        .dec_pc        (dec_pc),
        .dec_instr     (dec_instr),
        .dec_uncond_br (dec_uncond_br),
        .dec_ready     (dec_ready),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w[31:26] = 6'b000101;
        return w;
    endfunction

    // Compare outputs with the model, then advance the model and the clock together.
    task automatic step();
        logic [95:0] hd;
        bit          do_push;
        bit          do_pop;
        hd = (mq.size() > 0) ? mq[0] : 96'd0;
        if (chk_en) begin
            check("count",       64'(count),         64'(mq.size()));
            check("dec_valid",   64'(dec_valid),     64'(mq.size() != 0));
            check("fetch_ready", 64'(fetch_ready),   64'(mq.size() < DEPTH));
            check("dec_pc",      dec_pc,             hd[95:32]);
            check("dec_instr",   64'(dec_instr),     64'(hd[31:0]));
            check("dec_uncond",  64'(dec_uncond_br), 64'(mq.size() != 0 && hd[31:26] == 6'b000101));
        end
        do_push = fetch_valid && (mq.size() < DEPTH);
        do_pop  = dec_ready && (mq.size() > 0);
        if (reset || flush) begin
            mq.delete();
        end else begin
            if (do_pop) begin
                popped.push_back(hd[95:32]);
                void'(mq.pop_front());
            end
            if (do_push) mq.push_back({fetch_pc, fetch_instr});
        end
        if (mq.size() > max_count) max_count = mq.size();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [63:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_instr = rand_instr();
        step();
        fetch_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
        fetch_pc = '0; fetch_instr = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        step();
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_fready", 64'(fetch_ready), 64'd1);

        // Single push with uncond-branch opcode, then pop.
        fetch_valid = 1'b1; fetch_pc = 64'h10; fetch_instr = 32'h1400_0003;
        step();
        fetch_valid = 1'b0;
        check("single_pc", dec_pc, 64'h10);
        check("single_uncond", 64'(dec_uncond_br), 64'd1);
        check("single_count", 64'(count), 64'd1);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        check("single_empty", 64'(dec_valid), 64'd0);

        // Fill to full; held pair must wait for a pop and then one more edge.
        for (int i = 0; i < 4; i++) push_one(64'(i * 4));
        fetch_valid = 1'b1; fetch_pc = 64'h10; fetch_instr = 32'h0000_0010;
        for (int i = 0; i < 3; i++) step();
        check("full_count", 64'(count), 64'd4);
        check("full_fready", 64'(fetch_ready), 64'd0);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        check("full_head", dec_pc, 64'h4);
        check("full_hold_count", 64'(count), 64'd3);
        step();
        fetch_valid = 1'b0;
        check("full_refill", 64'(count), 64'd4);
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        dec_ready = 1'b0;
        check("full_tail", dec_pc, 64'h0);

        // Sustained push+pop at count 2.
        push_one(64'h100);
        push_one(64'h104);
        popped.delete();
        dec_ready = 1'b1; fetch_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fetch_pc = 64'h108 + 64'(i * 4);
            fetch_instr = rand_instr();
            step();
            check("thru_count", 64'(count), 64'd2);
        end
        fetch_valid = 1'b0;
        for (int i = 0; i < 5; i++) check("thru_order", popped[i], 64'h100 + 64'(i * 4));
        step(); step();
        dec_ready = 1'b0;

        // Flush at count 3 with push and pop in the same cycle.
        for (int i = 0; i < 3; i++) push_one(64'h200 + 64'(i * 4));
        flush = 1'b1; fetch_valid = 1'b1; dec_ready = 1'b1; fetch_pc = 64'h300;
        step();
        flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_fready", 64'(fetch_ready), 64'd1);
        push_one(64'h40);
        check("flush_redirect", dec_pc, 64'h40);

        // Mid-stream reset held two cycles at count 3.
        push_one(64'h44); push_one(64'h48);
        reset = 1'b1; fetch_valid = 1'b1; dec_ready = 1'b1; fetch_pc = 64'h500;
        step(); step();
        idle_inputs();
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_pc", dec_pc, 64'd0);

        // Wrap-around stream of 16 PCs with fetch holding its pair under back-pressure.
        popped.delete();
        max_count = 0;
        begin
            int sent;
            int cyc;
            sent = 0;
            cyc  = 0;
            while ((sent < 16 || mq.size() > 0) && cyc < 400) begin
                fetch_valid = (sent < 16);
                fetch_pc    = 64'(sent * 4);
                fetch_instr = 32'(sent);
                dec_ready   = ($urandom_range(0, 2) != 0);
                if (fetch_valid && mq.size() < DEPTH) sent++;
                step();
                cyc++;
            end
            check("wrap_done", 64'(cyc < 400), 64'd1);
        end
        idle_inputs();
        check("wrap_npop", 64'(popped.size()), 64'd16);
        for (int i = 0; i < 16 && i < popped.size(); i++) check("wrap_order", popped[i], 64'(i * 4));
        check("wrap_maxcnt", 64'(max_count <= DEPTH), 64'd1);

        // Fully random traffic including occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            fetch_valid = $urandom_range(0, 1);
            fetch_pc    = {$urandom, $urandom};
            fetch_instr = rand_instr();
            dec_ready   = $urandom_range(0, 1);
            flush       = ($urandom_range(0, 19) == 0);
            reset       = ($urandom_range(0, 49) == 0);
            step();
        end
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
